// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
//
// Purpose:
//   Serial-to-parallel front end of the 32-point FFT. Collects one complex
//   sample per valid/ready beat into a 32-entry frame and presents the frame
//   as one flat bus to the 32-wide register stage ahead of butterfly stage 1.
//   Two banks are used ping-pong, so frame k+1 can load while frame k is held
//   at the output.
//
// Configuration macro:
//   FFT_LOADER_BITREV_EN  defined   -> sample n is stored in slot bitrev5(n)
//                                      (input order for the DIT network)
//                         undefined -> sample n is stored in slot n
//
// Parameters:
//   bits     width of each real/imag part (signed two's complement)
//   fix_bit  fractional bits of the fixed-point format (carried, not used)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    sample {re[2*bits-1:bits], im[bits-1:0]}
//   in_valid   in_data valid
//   in_last    marks the 32nd sample of a frame (checked only)
//   in_ready   loader can accept a sample
//   out_frame  slot k = out_frame[k*2*bits +: 2*bits], k = 0..31
//   out_valid  out_frame holds a complete frame
//   out_ready  downstream consumes the frame
//   frame_err  sticky flag: in_last placement mismatch seen
// ---------------------------------------------------------------------------
module fft_input_loader #(
    parameter int bits    = 16,
    parameter int fix_bit = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*bits-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [64*bits-1:0]   out_frame,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err
);

    localparam int SW = 2 * bits;

    // The fixed-point position only matters downstream; reject nonsense here.
    if (fix_bit < 0 || fix_bit >= bits) begin : g_fix_bit_chk
        $error("fix_bit must lie in [0, bits-1]");
    end

    // Packed so that slot k of a bank lands at bits [k*SW +: SW] of out_frame.
    logic [31:0][SW-1:0] bank0;
    logic [31:0][SW-1:0] bank1;
    logic [1:0]          full;
    logic                wr_sel;
    logic                rd_sel;
    logic [4:0]          wr_cnt;

    logic accept;
    logic drain;
    logic last_beat;

    function automatic logic [4:0] slot(input logic [4:0] n);
`ifdef FFT_LOADER_BITREV_EN
        return {n[0], n[1], n[2], n[3], n[4]};
`else
        return n;
`endif
    endfunction

    assign in_ready  = !full[wr_sel] && !reset;
    assign out_valid = full[rd_sel];
    assign out_frame = rd_sel ? bank1 : bank0;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_beat = (wr_cnt == 5'd31);

    // Accept and drain always address different banks: accept needs the write
    // bank empty, drain needs the read bank full, so both may update full[]
    // in the same cycle without conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank0     <= '0;
            bank1     <= '0;
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= 5'd0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                if (wr_sel)
                    bank1[slot(wr_cnt)] <= in_data;
                else
                    bank0[slot(wr_cnt)] <= in_data;
                wr_cnt <= wr_cnt + 5'd1;
                if (last_beat) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
                // Framing is driven by the counter alone; in_last only flags.
                if (in_last != last_beat)
                    frame_err <= 1'b1;
            end
            if (drain) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

    localparam int BITS = 16;
    localparam int SW   = 2 * BITS;

    logic                clk = 1'b0;
    logic                reset;
    logic [SW-1:0]       in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [32*SW-1:0]    out_frame;
    logic                out_valid;
    logic                out_ready;
    logic                frame_err;

    fft_input_loader #(.bits(BITS), .fix_bit(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (frame-level) ----------------
    typedef logic [SW-1:0] frame_t [32];
    frame_t   fq[$];        // completed frames awaiting drain, oldest first
    frame_t   part;         // frame being collected, natural order
    int       m_cnt;
    bit       m_err;

    function automatic int slot_of(input int n);
        int r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int b = 0; b < 5; b++)
            if (((n >> b) & 1) != 0) r += (1 << (4 - b));
`else
        r = n;
`endif
        return r;
    endfunction

    function automatic logic [32*SW-1:0] expect_frame(input frame_t f);
        logic [32*SW-1:0] v;
        v = '0;
        for (int n = 0; n < 32; n++)
            v[slot_of(n)*SW +: SW] = f[n];
        return v;
    endfunction

    function automatic logic [SW-1:0] mk(input int re, input int im);
        logic [BITS-1:0] r, i;
        r = BITS'(re);
        i = BITS'(im);
        return {r, i};
    endfunction

    task automatic model_reset();
        fq.delete();
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [32*SW-1:0] exp);
        checks++;
        if (out_frame !== exp) begin
            errors++;
            for (int k = 0; k < 32; k++)
                if (out_frame[k*SW +: SW] !== exp[k*SW +: SW]) begin
                    $display("FAIL %s slot %0d actual=%0h required=%0h", nm, k,
                             out_frame[k*SW +: SW], exp[k*SW +: SW]);
                    break;
                end
        end
    endtask

    // One clock cycle: drive, compare against the model, advance model, clock.
    task automatic step(input logic v, input logic l, input logic [SW-1:0] d,
                        input logic ordy, input logic rst);
        bit acc, drn;
        reset = rst; in_valid = v; in_last = l; in_data = d; out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!rst && fq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(fq.size() > 0));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        if (fq.size() > 0) chk_frame("out_frame", expect_frame(fq[0]));
        if (rst) begin
            model_reset();
        end else begin
            acc = v && (fq.size() < 2);
            drn = (fq.size() > 0) && ordy;
            if (drn) void'(fq.pop_front());
            if (acc) begin
                part[m_cnt] = d;
                if (l != (m_cnt == 31)) m_err = 1'b1;
                m_cnt++;
                if (m_cnt == 32) begin
                    fq.push_back(part);
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Spot checks of the natural-ramp frame {n,-n}: slot -> expected sample.
    typedef struct {
        int          slot;
        logic [SW-1:0] exp;
    } slot_vec_t;
    slot_vec_t tbl[6];

    int hs;

    initial begin
`ifdef FFT_LOADER_BITREV_EN
        tbl[0] = '{16, mk(1, -1)};
        tbl[1] = '{1,  mk(16, -16)};
        tbl[2] = '{31, mk(31, -31)};
        tbl[3] = '{24, mk(3, -3)};
        tbl[4] = '{0,  mk(0, 0)};
        tbl[5] = '{5,  mk(20, -20)};
`else
        tbl[0] = '{5,  mk(5, -5)};
        tbl[1] = '{1,  mk(1, -1)};
        tbl[2] = '{31, mk(31, -31)};
        tbl[3] = '{16, mk(16, -16)};
        tbl[4] = '{0,  mk(0, 0)};
        tbl[5] = '{24, mk(24, -24)};
`endif

        // Reset held two cycles with traffic offered.
        reset = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = '1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_frame_zero", 64'(out_frame == '0), 64'd1);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        model_reset();

        // Ramp frame, no drain.
        for (int n = 0; n < 32; n++) step(1'b1, n == 31, mk(n, -n), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("ramp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("ramp_slot%0d", tbl[i].slot),
                64'(out_frame[tbl[i].slot*SW +: SW]), 64'(tbl[i].exp));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Backpressure: two frames fill both banks.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 64; k++) step(1'b1, (k % 32) == 31, SW'(k), 1'b0, 1'b0);
        in_valid = 1'b1;
        #1;
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("bp_in_ready_after_drain", 64'(in_ready), 64'd1);
        chk("bp_frame2_slot0", 64'(out_frame[0 +: SW]), 64'd32);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Overlap: 96 back-to-back samples with out_ready high.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        hs = 0;
        for (int k = 0; k < 96; k++) begin
            if (out_valid) hs++;
            step(1'b1, (k % 32) == 31, mk(k, 1000 + k), 1'b1, 1'b0);
        end
        if (out_valid) hs++;
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("overlap_handshakes", 64'(hs), 64'd3);

        // Framing error and reset mid-frame.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) step(1'b1, n == 10, mk(n, 7), 1'b0, 1'b0);
        chk("err_sticky", 64'(frame_err), 64'd1);
        step(1'b1, 1'b0, mk(20, 7), 1'b0, 1'b1);
        chk("err_cleared", 64'(frame_err), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_frame_zero", 64'(out_frame == '0), 64'd1);
        for (int n = 0; n < 32; n++) step(1'b1, n == 31, mk(-n, n * 3), 1'b0, 1'b0);
        chk("clean_out_valid", 64'(out_valid), 64'd1);
        chk("clean_frame_err", 64'(frame_err), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic v, l, o, r;
            v = ($urandom % 4) != 0;
            o = ($urandom % 3) != 0;
            r = ($urandom % 400) == 0;
            l = (m_cnt == 31);
            if (($urandom % 60) == 0) l = ~l;
            step(v, l, SW'($urandom), o, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
